// File: rtl/rst_release_seq_if.sv
// Soft-reset request and staged reset outputs of rst_release_seq.
interface rst_release_seq_if #(
  parameter int unsigned NUM_OUT = 3
);
  logic               ireq;
  logic [NUM_OUT-1:0] orst;
  logic               odone;
  logic               odrop;

  modport master (output ireq, input orst, input odone, input odrop);
  modport slave  (input ireq, output orst, output odone, output odrop);
endinterface

// File: rtl/rst_release_seq.sv
// Reset-release sequencer: async assert, synchronized and stretched release,
// then staged per-domain deassertion with a fixed gap.
module rst_release_seq #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned NUM_OUT     = 3,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             irst,
  rst_release_seq_if.slave bus
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {ST_SYNC, ST_HOLD, ST_REL, ST_DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] chain;
  logic [CW-1:0]          cnt;
  logic [NUM_OUT-1:0]     orst_q;
  logic [NUM_OUT-1:0]     orst_shl;
  logic                   odone_q;
  logic                   odrop_q;

  // Releasing the next domain is a left shift of the thermometer vector.
  assign orst_shl = orst_q << 1;

  always_ff @(posedge clk or posedge irst) begin
    if (irst) begin
      state   <= ST_SYNC;
      chain   <= '1;
      cnt     <= '0;
      orst_q  <= '1;
      odone_q <= 1'b0;
      odrop_q <= 1'b0;
    end else begin
      chain   <= {chain[SYNC_STAGES-2:0], 1'b0};
      odrop_q <= bus.ireq && (state != ST_DONE);
      case (state)
        // Leave SYNC on the edge the synchronizer output becomes 0.
        ST_SYNC: begin
          if (!chain[SYNC_STAGES-2]) begin
            state <= ST_HOLD;
            cnt   <= HOLD_LOAD;
          end
        end
        ST_HOLD, ST_REL: begin
          if (cnt == '0) begin
            orst_q <= orst_shl;
            cnt    <= GAP_LOAD;
            if (orst_shl == '0) begin
              odone_q <= 1'b1;
              state   <= ST_DONE;
            end else begin
              state <= ST_REL;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_DONE: begin
          if (bus.ireq) begin
            orst_q  <= '1;
            odone_q <= 1'b0;
            cnt     <= HOLD_LOAD;
            state   <= ST_HOLD;
          end
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

  assign bus.orst  = orst_q;
  assign bus.odone = odone_q;
  assign bus.odrop = odrop_q;

endmodule

// File: tb/tb_rst_release_seq.sv
// Directed bench for rst_release_seq: default build plus a minimal-parameter build.
module tb_rst_release_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic irst  = 1'b1;
  logic irst2 = 1'b1;

  rst_release_seq_if #(.NUM_OUT(3)) bus1 ();
  rst_release_seq_if #(.NUM_OUT(1)) bus2 ();

  rst_release_seq #(.SYNC_STAGES(2), .HOLD_CYCLES(4), .NUM_OUT(3), .GAP_CYCLES(2)) dut (
    .clk(clk), .irst(irst), .bus(bus1)
  );

  rst_release_seq #(.SYNC_STAGES(2), .HOLD_CYCLES(1), .NUM_OUT(1), .GAP_CYCLES(1)) dut2 (
    .clk(clk), .irst(irst2), .bus(bus2)
  );

  int total = 0;
  int bad   = 0;

  // Thermometer shape and odone consistency on every cycle.
  always @(negedge clk) begin
    logic [2:0] n;
    n = ~bus1.orst;
    total++;
    if (((n + 3'd1) & n) !== 3'd0) begin
      bad++;
      $display("FAIL thermometer: orst=%b required thermometer shape", bus1.orst);
    end
    total++;
    if (bus1.odone !== (bus1.orst == 3'b000)) begin
      bad++;
      $display("FAIL done_consistency: odone=%b orst=%b", bus1.odone, bus1.orst);
    end
    total++;
    if (bus2.odone !== (bus2.orst == 1'b0)) begin
      bad++;
      $display("FAIL done_consistency2: odone=%b orst=%b", bus2.odone, bus2.orst);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    irst = 1'b1;
    bus1.ireq = 1'b0;
    bus2.ireq = 1'b0;
    repeat (5) step();
    total++;
    if (bus1.orst !== 3'b111) begin bad++; $display("FAIL reset_orst: got %b want 111", bus1.orst); end
    total++;
    if (bus1.odone !== 1'b0) begin bad++; $display("FAIL reset_odone: got %b want 0", bus1.odone); end
    total++;
    if (bus1.odrop !== 1'b0) begin bad++; $display("FAIL reset_odrop: got %b want 0", bus1.odrop); end
  endtask

  // Releases irst just after an edge and checks edges 1..12.
  task automatic test_power_up(input string tag);
    logic [2:0] exp_orst [1:12];
    exp_orst = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b110,
                 3'b110, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000};
    irst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      total++;
      if (bus1.orst !== exp_orst[k]) begin
        bad++;
        $display("FAIL %s_orst edge %0d: got %b want %b", tag, k, bus1.orst, exp_orst[k]);
      end
      total++;
      if (bus1.odone !== (k >= 10)) begin
        bad++;
        $display("FAIL %s_odone edge %0d: got %b want %b", tag, k, bus1.odone, k >= 10);
      end
    end
  endtask

  task automatic test_soft_reset();
    logic [2:0] exp;
    bus1.ireq = 1'b1;
    step();
    bus1.ireq = 1'b0;
    total++;
    if (bus1.orst !== 3'b111 || bus1.odone !== 1'b0) begin
      bad++;
      $display("FAIL soft_accept: orst=%b odone=%b want 111/0", bus1.orst, bus1.odone);
    end
    for (int j = 1; j <= 9; j++) begin
      step();
      exp = (j < 4) ? 3'b111 : (j < 6) ? 3'b110 : (j < 8) ? 3'b100 : 3'b000;
      total++;
      if (bus1.orst !== exp || bus1.odone !== (j >= 8) || bus1.odrop !== 1'b0) begin
        bad++;
        $display("FAIL soft_seq e+%0d: orst=%b odone=%b odrop=%b want %b/%b/0",
                 j, bus1.orst, bus1.odone, bus1.odrop, exp, j >= 8);
      end
    end
  endtask

  task automatic test_dropped_request();
    irst = 1'b1;
    step();
    irst = 1'b0;
    repeat (6) step();
    bus1.ireq = 1'b1;
    step();
    bus1.ireq = 1'b0;
    total++;
    if (bus1.odrop !== 1'b1 || bus1.orst !== 3'b110) begin
      bad++;
      $display("FAIL drop_pulse: odrop=%b orst=%b want 1/110", bus1.odrop, bus1.orst);
    end
    step();
    total++;
    if (bus1.odrop !== 1'b0 || bus1.orst !== 3'b100) begin
      bad++;
      $display("FAIL drop_once: odrop=%b orst=%b want 0/100", bus1.odrop, bus1.orst);
    end
    step();
    total++;
    if (bus1.odone !== 1'b0) begin bad++; $display("FAIL drop_edge9: odone=%b want 0", bus1.odone); end
    step();
    total++;
    if (bus1.orst !== 3'b000 || bus1.odone !== 1'b1) begin
      bad++;
      $display("FAIL drop_edge10: orst=%b odone=%b want 000/1", bus1.orst, bus1.odone);
    end
  endtask

  task automatic test_mid_release();
    irst = 1'b1;
    step();
    irst = 1'b0;
    repeat (8) step();
    total++;
    if (bus1.orst !== 3'b100) begin bad++; $display("FAIL mid_pre: orst=%b want 100", bus1.orst); end
    #2;
    irst = 1'b1;
    #1;
    total++;
    if (bus1.orst !== 3'b111 || bus1.odone !== 1'b0) begin
      bad++;
      $display("FAIL mid_async: orst=%b odone=%b want 111/0", bus1.orst, bus1.odone);
    end
    step();
    bus1.ireq = 1'b1;
    step();
    bus1.ireq = 1'b0;
    step();
    total++;
    if (bus1.odrop !== 1'b0) begin bad++; $display("FAIL req_in_reset: odrop=%b want 0", bus1.odrop); end
    test_power_up("restart");
  endtask

  task automatic test_back_to_back();
    bus1.ireq = 1'b1;
    step();
    bus1.ireq = 1'b0;
    step();
    step();
    bus1.ireq = 1'b1;
    step();
    bus1.ireq = 1'b0;
    total++;
    if (bus1.odrop !== 1'b1 || bus1.orst !== 3'b111) begin
      bad++;
      $display("FAIL b2b_drop: odrop=%b orst=%b want 1/111", bus1.odrop, bus1.orst);
    end
    step();
    total++;
    if (bus1.odrop !== 1'b0 || bus1.orst !== 3'b110) begin
      bad++;
      $display("FAIL b2b_e4: odrop=%b orst=%b want 0/110", bus1.odrop, bus1.orst);
    end
    repeat (3) step();
    total++;
    if (bus1.orst !== 3'b100 || bus1.odone !== 1'b0) begin
      bad++;
      $display("FAIL b2b_e7: orst=%b odone=%b want 100/0", bus1.orst, bus1.odone);
    end
    step();
    total++;
    if (bus1.orst !== 3'b000 || bus1.odone !== 1'b1) begin
      bad++;
      $display("FAIL b2b_e8: orst=%b odone=%b want 000/1", bus1.orst, bus1.odone);
    end
    bus1.ireq = 1'b1;
    step();
    bus1.ireq = 1'b0;
    total++;
    if (bus1.orst !== 3'b111 || bus1.odone !== 1'b0 || bus1.odrop !== 1'b0) begin
      bad++;
      $display("FAIL b2b_third: orst=%b odone=%b odrop=%b want 111/0/0",
               bus1.orst, bus1.odone, bus1.odrop);
    end
    repeat (8) step();
    total++;
    if (bus1.orst !== 3'b000 || bus1.odone !== 1'b1) begin
      bad++;
      $display("FAIL b2b_third_done: orst=%b odone=%b want 000/1", bus1.orst, bus1.odone);
    end
  endtask

  task automatic test_param_sweep();
    irst2 = 1'b1;
    step();
    total++;
    if (bus2.orst !== 1'b1 || bus2.odone !== 1'b0) begin
      bad++;
      $display("FAIL sweep_reset: orst=%b odone=%b want 1/0", bus2.orst, bus2.odone);
    end
    irst2 = 1'b0;
    step();
    step();
    total++;
    if (bus2.orst !== 1'b1 || bus2.odone !== 1'b0) begin
      bad++;
      $display("FAIL sweep_edge2: orst=%b odone=%b want 1/0", bus2.orst, bus2.odone);
    end
    step();
    total++;
    if (bus2.orst !== 1'b0 || bus2.odone !== 1'b1) begin
      bad++;
      $display("FAIL sweep_edge3: orst=%b odone=%b want 0/1", bus2.orst, bus2.odone);
    end
    bus2.ireq = 1'b1;
    step();
    bus2.ireq = 1'b0;
    total++;
    if (bus2.orst !== 1'b1 || bus2.odone !== 1'b0) begin
      bad++;
      $display("FAIL sweep_soft: orst=%b odone=%b want 1/0", bus2.orst, bus2.odone);
    end
    step();
    total++;
    if (bus2.orst !== 1'b0 || bus2.odone !== 1'b1) begin
      bad++;
      $display("FAIL sweep_soft_rel: orst=%b odone=%b want 0/1", bus2.orst, bus2.odone);
    end
  endtask

  initial begin
    bus1.ireq = 1'b0;
    bus2.ireq = 1'b0;
    test_reset();
    test_power_up("power_up");
    test_soft_reset();
    test_dropped_request();
    test_mid_release();
    test_back_to_back();
    test_param_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
